pll_lock_rst_gen: RTL and testbench
===================================

Name: pll_lock_rst_gen

Overview:
- Reset sequencer directly downstream of the board GPLL wrapper; consumes its `lock` output and drives its `rst` input.
- Runs on the free-running board reference clock (50 MHz, same net as PLL clkin1).
- Pulses PLL reset, waits for a stable lock (with timeout and retry), then releases NUM_RST active-high domain resets in sequence.
- Any lock loss re-asserts all domain resets immediately.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000: cycles to wait for synced lock before retrying (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synced-lock-high cycles required before release.
- NUM_RST, 4: number of domain reset outputs (1..8).
- STAGE_GAP, 64: cycles between successive rst_out bit releases (>=1).
- MAX_RETRY, 7: failed lock attempts before entering FAIL; 0 = retry forever.

Ports:
- clk  input  1  free-running reference clock
- rst  input  1  asynchronous active-high reset
- lock  input  1  PLL lock, asynchronous to clk
- pll_rst  output  1  to PLL rst input, active high
- rst_out  output  NUM_RST  domain resets, active high; bit 0 released first
- ready  output  1  high when all rst_out released and state RUN
- fail  output  1  retry budget exhausted
- retry_cnt  output  8  attempts made since rst, saturating at 255

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous and active-high.
- Values while rst is high: pll_rst=1, rst_out=all 1, ready=0, fail=0, retry_cnt=0, state=PLL_RST, counters=0.
- lock synchroniser: 2-flop synchroniser, lock_s. lock_s lags lock by 2–3 clk edges. All decisions use lock_s only.
- PLL_RST:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK and deassert pll_rst in the same edge.
- WAIT_LOCK:
  - Timer counts 1..LOCK_TIMEOUT.
  - lock_s=1 -> STABLE, with the stable counter cleared.
  - Timer reaches LOCK_TIMEOUT -> retry_cnt++ (saturating).
    - If MAX_RETRY!=0 and retry_cnt+1 >= MAX_RETRY -> FAIL.
    - Otherwise -> PLL_RST.
- STABLE:
  - Counter increments while lock_s=1.
  - lock_s=0 -> back to WAIT_LOCK, timer cleared, no retry increment.
  - Counter reaches LOCK_STABLE_CYCLES -> RELEASE.
- RELEASE:
  - First rst_out[0] deasserts on the first cycle in RELEASE.
  - Each further bit i deasserts STAGE_GAP cycles after bit i-1.
  - After bit NUM_RST-1 deasserts -> RUN.
- RUN:
  - ready=1 (registered, asserts the cycle after entering RUN).
  - lock_s=0 -> all rst_out=1 and ready=0 on the next edge; go to PLL_RST; retry_cnt unchanged.
- Lock drop in RELEASE: same as RUN; already-released bits re-assert simultaneously.
- FAIL:
  - fail=1, pll_rst=1, rst_out all 1.
  - Sticky until rst.
- Width rules:
  - Timer width = clog2(max(LOCK_TIMEOUT, LOCK_STABLE_CYCLES, PLL_RST_CYCLES, STAGE_GAP)+1); a single shared down-counter is permitted.
  - All comparisons are unsigned.
- Output timing: all outputs registered; no combinational path from lock to any output.
- Reset mid-operation: rst asserted in any state returns all outputs to reset values asynchronously; the sequence restarts at PLL_RST.

Optional Feature:
- Macro: PLL_LOCK_LOSS_CNT_EN.
- When defined:
  - Adds output loss_cnt [15:0]: saturating count of RUN/RELEASE->PLL_RST lock-loss events, cleared only by rst.
  - Adds output lock_lost_sticky [0:0]: set on the first such event, cleared only by rst.
- When undefined: neither port exists and no related logic is built; all other behaviour is identical.

Decomposition:
- Package pll_rst_pkg:
  - State enum {PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL}, 3-bit.
  - Constant RETRY_W=8.
  - clog2 helper function.
- One sub-module: sync_2ff (parameterised-width 2-flop synchroniser with async active-high reset to 0), instantiated for lock.

Test Plan (bench params: PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE_CYCLES=20, NUM_RST=3, STAGE_GAP=5, MAX_RETRY=3):
- Normal bring-up: lock rises 10 cycles after pll_rst falls and stays high -> pll_rst high exactly 4 cycles; rst_out[0] falls 20 cycles after lock_s rises; rst_out[1] falls 5 cycles after bit 0, rst_out[2] 5 cycles after bit 1; ready=1 one cycle after that; retry_cnt=0.
- Glitchy lock: lock high 8 cycles, low 3, then high -> STABLE count restarts; release occurs 20 cycles after the final rise; retry_cnt stays 0.
- Timeout/retry: lock held 0 -> pll_rst pulses every 104 cycles (4+100); after the 3rd timeout fail=1 and pll_rst stays 1; retry_cnt=3; later lock=1 has no effect.
- Lock loss in RUN: drop lock for 1 cycle -> within 3 edges all rst_out=1 and ready=0; new 4-cycle pll_rst pulse follows; full sequence repeats. With PLL_LOCK_LOSS_CNT_EN, loss_cnt=1 and sticky=1.
- Lock loss mid-RELEASE (after bit 0 released only) -> bit 0 re-asserts and bits 1–2 stay high; sequence restarts at PLL_RST.
- Async reset in RUN: rst pulsed between clk edges -> outputs take reset values immediately (before the next edge); retry_cnt=0; sequence restarts.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL lock / reset sequencer.
`timescale 1ns/1ps
package pll_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAIL
  } state_t;

  localparam int unsigned RETRY_W = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned w;
    v = (value > 0) ? value - 1 : 0;
    w = 0;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return w;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_rst_gen_sync_2ff.sv
// Parameterised-width two-flop synchroniser, async active-high reset to 0.
`timescale 1ns/1ps
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_rst_gen.sv
// PLL reset / lock qualification and staged domain-reset release.
// Optional lock-loss statistics ports are built when PLL_LOCK_LOSS_CNT_EN is defined.
//
// state     | meaning
// PLL_RST   | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK | waiting up to LOCK_TIMEOUT cycles for synced lock
// STABLE    | counting consecutive synced-lock cycles
// RELEASE   | releasing rst_out bits, STAGE_GAP apart, bit 0 first
// RUN       | all domains out of reset, ready high
// FAIL      | retry budget spent; sticky until rst
`timescale 1ns/1ps
module pll_lock_rst_gen
  import pll_rst_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned NUM_RST            = 4,
  parameter int unsigned STAGE_GAP          = 64,
  parameter int unsigned MAX_RETRY          = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lock,
  output logic               pll_rst,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [15:0]        loss_cnt,
  output logic [0:0]         lock_lost_sticky
`endif
);

  localparam int unsigned MAX_CYC =
    max2(max2(LOCK_TIMEOUT, LOCK_STABLE_CYCLES), max2(PLL_RST_CYCLES, STAGE_GAP));
  localparam int unsigned TW = clog2(MAX_CYC + 1);

  state_t             state;
  logic [TW-1:0]      cnt;
  logic               lock_s;
  logic [NUM_RST-1:0] rst_shift;
  logic [RETRY_W:0]   retry_inc;
  logic [RETRY_W-1:0] retry_sat;
  logic               retry_spent;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock),
    .q   (lock_s)
  );

  // Releasing the next bit is a left shift of the still-asserted mask.
  assign rst_shift   = rst_out << 1;
  assign retry_inc   = {1'b0, retry_cnt} + 1'b1;
  assign retry_sat   = retry_inc[RETRY_W] ? retry_cnt : retry_inc[RETRY_W-1:0];
  assign retry_spent = (MAX_RETRY != 0) && (32'(retry_inc) >= MAX_RETRY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      rst_out   <= '1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == TW'(PLL_RST_CYCLES - 1)) begin
            state   <= WAIT_LOCK;
            pll_rst <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TW'(LOCK_TIMEOUT - 1)) begin
            retry_cnt <= retry_sat;
            pll_rst   <= 1'b1;
            cnt       <= '0;
            if (retry_spent) begin
              state <= FAIL;
              fail  <= 1'b1;
            end else begin
              state <= PLL_RST;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == TW'(LOCK_STABLE_CYCLES - 1)) begin
            state   <= (rst_shift == '0) ? RUN : RELEASE;
            rst_out <= rst_shift;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            state   <= PLL_RST;
            pll_rst <= 1'b1;
            rst_out <= '1;
            cnt     <= '0;
          end else if (cnt == TW'(STAGE_GAP - 1)) begin
            rst_out <= rst_shift;
            cnt     <= '0;
            if (rst_shift == '0) state <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state   <= PLL_RST;
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
            cnt     <= '0;
          end else begin
            ready <= 1'b1;
          end
        end
        FAIL: begin
          pll_rst <= 1'b1;
          rst_out <= '1;
          ready   <= 1'b0;
          fail    <= 1'b1;
        end
        default: begin
          state   <= PLL_RST;
          pll_rst <= 1'b1;
          rst_out <= '1;
          ready   <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  // Only losses after qualification count; drops during STABLE are part of acquisition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt         <= '0;
      lock_lost_sticky <= '0;
    end else if ((state == RUN || state == RELEASE) && !lock_s) begin
      if (loss_cnt != 16'hFFFF) loss_cnt <= loss_cnt + 1'b1;
      lock_lost_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// Directed bench for pll_lock_rst_gen with small timing parameters.
`timescale 1ns/1ps
module tb_pll_lock_rst_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       pll_rst;
  logic [2:0] rst_out;
  logic       ready;
  logic       fail;
  logic [7:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [15:0] loss_cnt;
  logic [0:0]  lock_lost_sticky;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pll_lock_rst_gen #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (100),
    .LOCK_STABLE_CYCLES (20),
    .NUM_RST            (3),
    .STAGE_GAP          (5),
    .MAX_RETRY          (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lock      (lock),
    .pll_rst   (pll_rst),
    .rst_out   (rst_out),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt)
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    .loss_cnt         (loss_cnt),
    .lock_lost_sticky (lock_lost_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    lock = 1'b0;
    #12;
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_rst_out", 32'(rst_out), 7);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // normal bring-up
    step(3);  chk("up_pll_rst_hi", 32'(pll_rst), 1);
    step(1);  chk("up_pll_rst_lo", 32'(pll_rst), 0);
    step(10); lock = 1'b1;
    step(22); chk("up_hold_all", 32'(rst_out), 7);
    step(1);  chk("up_bit0", 32'(rst_out), 6);
    chk("up_retry", 32'(retry_cnt), 0);
    step(4);  chk("up_bit1_hold", 32'(rst_out), 6);
    step(1);  chk("up_bit1", 32'(rst_out), 4);
    step(4);  chk("up_bit2_hold", 32'(rst_out), 4);
    step(1);  chk("up_bit2", 32'(rst_out), 0);
    chk("up_ready_lat", 32'(ready), 0);
    step(1);  chk("up_ready", 32'(ready), 1);
    chk("up_pll_rst_run", 32'(pll_rst), 0);
    chk("up_fail", 32'(fail), 0);

    // one-cycle lock loss in RUN
    lock = 1'b0;
    step(1);  lock = 1'b1;
    step(1);  chk("loss_sync_rst_out", 32'(rst_out), 0);
    chk("loss_sync_ready", 32'(ready), 1);
    step(1);  chk("loss_rst_out", 32'(rst_out), 7);
    chk("loss_ready", 32'(ready), 0);
    chk("loss_pll_rst", 32'(pll_rst), 1);
    step(3);  chk("loss_pll_rst_hi", 32'(pll_rst), 1);
    step(1);  chk("loss_pll_rst_lo", 32'(pll_rst), 0);
    step(20); chk("loss_hold_all", 32'(rst_out), 7);
    step(1);  chk("loss_bit0", 32'(rst_out), 6);
    step(10); chk("loss_all_rel", 32'(rst_out), 0);
    step(1);  chk("loss_ready_again", 32'(ready), 1);
    chk("loss_retry", 32'(retry_cnt), 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("loss_cnt1", 32'(loss_cnt), 1);
    chk("loss_sticky1", 32'(lock_lost_sticky), 1);
`endif

    // async reset between edges while in RUN
    #2 rst = 1'b1;
    lock = 1'b0;
    #1;
    chk("arst_pll_rst", 32'(pll_rst), 1);
    chk("arst_rst_out", 32'(rst_out), 7);
    chk("arst_ready", 32'(ready), 0);
    chk("arst_retry", 32'(retry_cnt), 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("arst_loss_cnt", 32'(loss_cnt), 0);
    chk("arst_sticky", 32'(lock_lost_sticky), 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // glitchy lock: high 8, low 3, then high
    step(4);  chk("gl_pll_rst_lo", 32'(pll_rst), 0);
    lock = 1'b1;
    step(8);  lock = 1'b0;
    step(3);  lock = 1'b1;
    step(22); chk("gl_hold_all", 32'(rst_out), 7);
    step(1);  chk("gl_bit0", 32'(rst_out), 6);
    chk("gl_retry", 32'(retry_cnt), 0);

    // lock loss after only bit 0 released
    lock = 1'b0;
    step(2);  chk("mid_bit0_still", 32'(rst_out), 6);
    step(1);  chk("mid_rst_out", 32'(rst_out), 7);
    chk("mid_pll_rst", 32'(pll_rst), 1);
    chk("mid_ready", 32'(ready), 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("mid_loss_cnt", 32'(loss_cnt), 1);
    chk("mid_sticky", 32'(lock_lost_sticky), 1);
`endif

    // lock stays low: timeout, retry, then FAIL
    step(3);  chk("to_pll_rst_hi", 32'(pll_rst), 1);
    step(1);  chk("to_pll_rst_lo", 32'(pll_rst), 0);
    step(99); chk("to1_before_pll", 32'(pll_rst), 0);
    chk("to1_before_retry", 32'(retry_cnt), 0);
    step(1);  chk("to1_pll_rst", 32'(pll_rst), 1);
    chk("to1_retry", 32'(retry_cnt), 1);
    chk("to1_fail", 32'(fail), 0);
    step(4);  chk("to2_pll_rst_lo", 32'(pll_rst), 0);
    step(99); chk("to2_before_retry", 32'(retry_cnt), 1);
    step(1);  chk("to2_retry", 32'(retry_cnt), 2);
    chk("to2_pll_rst", 32'(pll_rst), 1);
    step(4);  chk("to3_pll_rst_lo", 32'(pll_rst), 0);
    step(99); chk("to3_before_fail", 32'(fail), 0);
    chk("to3_before_retry", 32'(retry_cnt), 2);
    step(1);  chk("to3_fail", 32'(fail), 1);
    chk("to3_retry", 32'(retry_cnt), 3);
    chk("to3_pll_rst", 32'(pll_rst), 1);
    chk("to3_rst_out", 32'(rst_out), 7);
    lock = 1'b1;
    step(50); chk("fail_sticky", 32'(fail), 1);
    chk("fail_pll_rst", 32'(pll_rst), 1);
    chk("fail_rst_out", 32'(rst_out), 7);
    chk("fail_ready", 32'(ready), 0);
    chk("fail_retry", 32'(retry_cnt), 3);

    // reset clears FAIL
    #2 rst = 1'b1;
    #1;
    chk("end_fail_clr", 32'(fail), 0);
    chk("end_retry_clr", 32'(retry_cnt), 0);
    chk("end_pll_rst", 32'(pll_rst), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
